delay_line_engine: RTL
======================

Name: delay_line_engine

Overview:
- Parametrised successor to the single-tap delay manager: N independent circular delay lines share one block RAM.
- Adds a fractional delay with linear interpolation, a per-sample delay slew with clamping, a per-channel fade-in gain ramp, saturation, and a valid/ready request handshake.
- Sits between the effect pipeline (sample producer/consumer) and on-chip RAM.
- Services one channel request at a time through a single FSM.

Parameters:
- DATA_W, 16, signed sample width.
- N_CH, 32, number of delay channels; CH_W = clog2(N_CH).
- MEM_DEPTH, 4096, RAM words; ADDR_W = clog2(MEM_DEPTH).
- FRAC_BITS, 8, fractional delay bits; DELAY_W = ADDR_W + FRAC_BITS.
- GAIN_FRAC, 14, gain Q format; unity gain = 1<<GAIN_FRAC.
- GAIN_STEP, 64, gain increment per processed sample after first wrap.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  clock enable; low freezes all state
- alloc_req  in  1  allocate next channel (single-cycle pulse)
- alloc_size  in  ADDR_W  ring length in words
- alloc_delay  in  DELAY_W  initial delay, Q(ADDR_W.FRAC_BITS) samples
- alloc_ack  out  1  pulse: allocation done
- alloc_handle  out  CH_W  handle assigned
- alloc_err  out  1  pulse: allocation rejected
- req_valid  in  1  process request
- req_ready  out  1  engine can accept
- req_handle  in  CH_W  target channel
- req_data  in  DATA_W  signed sample to write
- req_delay_inc  in  DATA_W  signed delay change, Q.FRAC_BITS
- req_err  out  1  pulse: request to an unallocated handle
- out_valid  out  1  pulse: output sample valid
- out_handle  out  CH_W  channel of out_data
- out_data  out  DATA_W  delayed, interpolated, gained sample

Behaviour:
- Reset (async, reset==0):
  - All outputs 0; FSM to IDLE; n_alloc=0, next_base=0.
  - Channel table cleared: base, size, delay, pos, wrapped, gain = 0.
  - Reset mid-operation aborts the request; no out_valid follows.
  - RAM contents are not cleared.
- Priority and readiness:
  - req_ready = enable & (state==IDLE) & !alloc_req.
  - Alloc has priority over a request in the same cycle.
- Alloc (IDLE only), result next cycle:
  - Reject with alloc_err if n_alloc==N_CH, size<2, or next_base+size>MEM_DEPTH.
  - Otherwise write channel[n_alloc]: base=next_base, size, delay=min(alloc_delay, (size-1)<<FRAC_BITS), pos=0, gain=0, wrapped=0.
  - Then pulse alloc_ack with alloc_handle=n_alloc; n_alloc++; next_base += size.
- Request accept:
  - On req_valid&req_ready, latch handle/data/inc.
  - Handle >= n_alloc: pulse req_err next cycle, return to IDLE, no output.
- FSM IDLE->WR->RD0->RD1->MIX->OUT->IDLE:
  - WR: RAM[base+pos] <= data.
  - RD0: read tap0 = base + ((pos - d) mod size), where d = delay>>FRAC_BITS.
  - RD1: read tap1 = base + ((pos - d - 1) mod size).
  - MIX: y = s0 + (((s1-s0) * f) >>> FRAC_BITS), with f = delay[FRAC_BITS-1:0]. Then z = (y*gain) >>> GAIN_FRAC, saturated to DATA_W.
  - OUT: out_valid=1 for exactly one cycle, with out_handle and out_data=z.
  - Latency: out_valid 5 cycles after the accept edge; next accept possible the cycle after OUT.
- Write/read ordering: the write precedes both reads, so d=0 returns the sample just written.
- Modulo arithmetic: pos-d underflow wraps by adding size; no address leaves [base, base+size).
- Delay update in OUT:
  - delay <= clamp(delay + inc, 0, (size-1)<<FRAC_BITS).
  - Sign-extend inc to DELAY_W+1 before the add.
- Position update in OUT: pos <= (pos==size-1) ? 0 : pos+1. The wrap sets wrapped=1.
- Gain update in OUT: if wrapped, gain <= min(gain+GAIN_STEP, 1<<GAIN_FRAC). The output before the first wrap is therefore 0.
- enable=0: no state changes, req_ready=0, and pulse outputs do not assert.

Optional Feature:
- Macro: DELAY_INTERP_EN.
- Defined: two-tap linear interpolation as above; latency 5.
- Undefined:
  - RD1 is skipped; y = s0 and the fractional delay bits are ignored for addressing but still accumulate.
  - Latency 4.
  - The tap1 logic and the multiplier for (s1-s0)*f are not synthesised.

Test Plan:
- Reset low mid-request (after WR) -> all outputs 0, no out_valid; alloc after release returns handle 0, base 0.
- Alloc size=8, delay=3<<8; 8 requests with data 1..8 -> outputs 0 (gain 0). Continue: gain ramps by 64 per sample; with gain forced to unity via 256 requests, out_data equals input delayed by 3.
- Delay 2.5 (0x280), unity gain, samples 100,200,300,400 -> 4th output = (200+100)/2 = 150 (DELAY_INTERP_EN); without the macro -> 200.
- delay_inc=+0x7FFF on size=8 -> delay clamps to 7<<8; delay_inc=-0x8000 -> clamps to 0; d=0 output equals the current input.
- Alloc while n_alloc=N_CH, or size exceeding remaining memory (4000 then 200) -> alloc_err, n_alloc unchanged. Request to handle 5 with n_alloc=2 -> req_err, no out_valid.
- alloc_req and req_valid in the same cycle -> alloc_ack; req_ready low that cycle; request accepted next cycle with latency 5.

Source files
------------

// File: rtl/delay_line_engine.sv
// delay_line_engine
//   N_CH circular delay lines sharing one RAM. One channel request is
//   serviced at a time: write the new sample, read one or two taps, blend
//   them by the fractional delay, apply the fade-in gain, saturate, emit.
//   Between samples the delay slews by a signed increment, clamped to the
//   ring length.
//
// Ports
//   clk, reset (async, active low), enable (low freezes all state)
//   alloc_req/size/delay -> alloc_ack/handle/err : channel allocation
//   req_valid/ready/handle/data/delay_inc, req_err : sample request
//   out_valid/handle/data                          : processed sample
//
// Build option
//   DELAY_INTERP_EN : defined -> two-tap linear interpolation, latency 5.
//                     undefined -> single tap, fractional bits still
//                     accumulate but do not address, latency 4.
module delay_line_engine #(
  parameter  int DATA_W    = 16,
  parameter  int N_CH      = 32,
  parameter  int MEM_DEPTH = 4096,
  parameter  int FRAC_BITS = 8,
  parameter  int GAIN_FRAC = 14,
  parameter  int GAIN_STEP = 64,
  localparam int CH_W      = $clog2(N_CH),
  localparam int ADDR_W    = $clog2(MEM_DEPTH),
  localparam int DELAY_W   = ADDR_W + FRAC_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               alloc_req,
  input  logic [ADDR_W-1:0]  alloc_size,
  input  logic [DELAY_W-1:0] alloc_delay,
  output logic               alloc_ack,
  output logic [CH_W-1:0]    alloc_handle,
  output logic               alloc_err,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CH_W-1:0]    req_handle,
  input  logic [DATA_W-1:0]  req_data,
  input  logic [DATA_W-1:0]  req_delay_inc,
  output logic               req_err,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_handle,
  output logic [DATA_W-1:0]  out_data
);
  localparam int GW = GAIN_FRAC + 1;
  localparam int PW = DATA_W + GAIN_FRAC + 4;
  localparam logic [GW-1:0] G_UNITY = {1'b1, {GAIN_FRAC{1'b0}}};
  localparam logic [GW-1:0] G_STEP  = GW'(GAIN_STEP);

  typedef struct packed {
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  size;
    logic [ADDR_W-1:0]  pos;
    logic [DELAY_W-1:0] delay;
    logic               wrapped;
    logic [GW-1:0]      gain;
  } chan_t;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD0, S_RD1, S_MIX, S_OUT} state_t;

  state_t              state_q, state_d;
  chan_t               chan_q [N_CH];
  chan_t               chan_d [N_CH];
  logic [CH_W:0]       n_alloc_q, n_alloc_d;
  logic [ADDR_W:0]     next_base_q, next_base_d;
  logic [CH_W-1:0]     hdl_q, hdl_d, alloc_handle_q, alloc_handle_d;
  logic [DATA_W-1:0]   data_q, data_d, inc_q, inc_d, out_data_q, out_data_d;
  logic                alloc_ack_q, alloc_ack_d, alloc_err_q, alloc_err_d;
  logic                req_err_q, req_err_d;

  logic [DATA_W-1:0]   mem [MEM_DEPTH];
  logic [DATA_W-1:0]   ram_rdata_q, ram_rdata_d;

  chan_t               cur;
  logic                accept, alloc_go, alloc_bad, hdl_ok;
  logic [ADDR_W+1:0]   alloc_end;
  logic [DELAY_W-1:0]  alloc_dmax, delay_max, delay_new;
  logic [ADDR_W-1:0]   d_int, off0, raddr, waddr;
  logic signed [DELAY_W:0] inc_ext, delay_sum;
  logic signed [DATA_W+1:0] y;
  logic signed [PW-1:0] yg, zsh;
  logic [DATA_W-1:0]   z;
  logic [GW-1:0]       gain_inc;

  assign cur       = chan_q[hdl_q];
  assign accept    = req_valid & req_ready;
  assign alloc_go  = enable & (state_q == S_IDLE) & alloc_req;
  assign hdl_ok    = {1'b0, req_handle} < n_alloc_q;
  assign alloc_end = {1'b0, next_base_q} + {2'b00, alloc_size};
  assign alloc_bad = (n_alloc_q == (CH_W+1)'(N_CH)) || (alloc_size < ADDR_W'(2)) ||
                     (alloc_end > (ADDR_W+2)'(MEM_DEPTH));
  assign alloc_dmax = {alloc_size - 1'b1, {FRAC_BITS{1'b0}}};

  // Tap offsets within the ring; d never exceeds size-1, so a single
  // conditional add of size is enough to wrap an underflow.
  assign d_int = cur.delay[DELAY_W-1:FRAC_BITS];
  assign off0  = (cur.pos >= d_int) ? cur.pos - d_int : cur.pos + cur.size - d_int;
  assign waddr = cur.base + cur.pos;

`ifdef DELAY_INTERP_EN
  logic [ADDR_W-1:0]              off1;
  logic [DATA_W-1:0]              s0_q, s0_d;
  logic signed [DATA_W:0]         diff;
  logic signed [DATA_W+FRAC_BITS+1:0] prod;
  logic signed [DATA_W+1:0]       s0x, blend;

  assign off1  = (off0 == '0) ? cur.size - 1'b1 : off0 - 1'b1;
  assign raddr = cur.base + ((state_q == S_RD1) ? off1 : off0);
  // s0 was captured when tap1 was issued; ram_rdata_q now holds s1.
  assign diff  = {ram_rdata_q[DATA_W-1], ram_rdata_q} - {s0_q[DATA_W-1], s0_q};
  assign prod  = diff * $signed({1'b0, cur.delay[FRAC_BITS-1:0]});
  assign s0x   = {{2{s0_q[DATA_W-1]}}, s0_q};
  assign blend = prod[DATA_W+FRAC_BITS+1:FRAC_BITS];
  assign y     = s0x + blend;
`else
  assign raddr = cur.base + off0;
  assign y     = {{2{ram_rdata_q[DATA_W-1]}}, ram_rdata_q};
`endif

  assign yg  = y * $signed({1'b0, cur.gain});
  assign zsh = yg >>> GAIN_FRAC;
  always_comb begin
    if ((&zsh[PW-1:DATA_W-1]) || (~|zsh[PW-1:DATA_W-1])) z = zsh[DATA_W-1:0];
    else if (zsh[PW-1])                                   z = {1'b1, {(DATA_W-1){1'b0}}};
    else                                                  z = {1'b0, {(DATA_W-1){1'b1}}};
  end

  // Delay slew: signed add in DELAY_W+1 bits, clamp to [0, (size-1)<<FRAC].
  assign inc_ext   = {{(DELAY_W+1-DATA_W){inc_q[DATA_W-1]}}, inc_q};
  assign delay_sum = $signed({1'b0, cur.delay}) + inc_ext;
  assign delay_max = {cur.size - 1'b1, {FRAC_BITS{1'b0}}};
  always_comb begin
    if (delay_sum[DELAY_W])                       delay_new = '0;
    else if (delay_sum[DELAY_W-1:0] > delay_max)  delay_new = delay_max;
    else                                          delay_new = delay_sum[DELAY_W-1:0];
  end
  assign gain_inc = cur.gain + G_STEP;

  // Next-state
  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        S_IDLE:  if (accept && hdl_ok) state_d = S_WR;
        S_WR:    state_d = S_RD0;
`ifdef DELAY_INTERP_EN
        S_RD0:   state_d = S_RD1;
        S_RD1:   state_d = S_MIX;
`else
        S_RD0:   state_d = S_MIX;
`endif
        S_MIX:   state_d = S_OUT;
        S_OUT:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and channel table
  always_comb begin
    chan_d         = chan_q;
    n_alloc_d      = n_alloc_q;
    next_base_d    = next_base_q;
    hdl_d          = hdl_q;
    data_d         = data_q;
    inc_d          = inc_q;
    out_data_d     = out_data_q;
    alloc_handle_d = alloc_handle_q;
    alloc_ack_d    = alloc_ack_q;
    alloc_err_d    = alloc_err_q;
    req_err_d      = req_err_q;
`ifdef DELAY_INTERP_EN
    s0_d           = s0_q;
`endif
    if (enable) begin
      alloc_ack_d = 1'b0;
      alloc_err_d = 1'b0;
      req_err_d   = 1'b0;
      if (alloc_go) begin
        if (alloc_bad) alloc_err_d = 1'b1;
        else begin
          chan_d[n_alloc_q[CH_W-1:0]].base    = next_base_q[ADDR_W-1:0];
          chan_d[n_alloc_q[CH_W-1:0]].size    = alloc_size;
          chan_d[n_alloc_q[CH_W-1:0]].pos     = '0;
          chan_d[n_alloc_q[CH_W-1:0]].delay   = (alloc_delay < alloc_dmax) ? alloc_delay : alloc_dmax;
          chan_d[n_alloc_q[CH_W-1:0]].wrapped = 1'b0;
          chan_d[n_alloc_q[CH_W-1:0]].gain    = '0;
          alloc_ack_d    = 1'b1;
          alloc_handle_d = n_alloc_q[CH_W-1:0];
          n_alloc_d      = n_alloc_q + 1'b1;
          next_base_d    = alloc_end[ADDR_W:0];
        end
      end else if (accept) begin
        hdl_d  = req_handle;
        data_d = req_data;
        inc_d  = req_delay_inc;
        if (!hdl_ok) req_err_d = 1'b1;
      end
`ifdef DELAY_INTERP_EN
      if (state_q == S_RD1) s0_d = ram_rdata_q;
`endif
      if (state_q == S_MIX) out_data_d = z;
      if (state_q == S_OUT) begin
        chan_d[hdl_q].delay = delay_new;
        // gain ramps only on samples after the first wrap (old wrapped flag)
        if (cur.wrapped) chan_d[hdl_q].gain = (gain_inc > G_UNITY) ? G_UNITY : gain_inc;
        if (cur.pos == cur.size - 1'b1) begin
          chan_d[hdl_q].pos     = '0;
          chan_d[hdl_q].wrapped = 1'b1;
        end else begin
          chan_d[hdl_q].pos = cur.pos + 1'b1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    req_ready    = reset & enable & (state_q == S_IDLE) & ~alloc_req;
    out_valid    = enable & (state_q == S_OUT);
    alloc_ack    = enable & alloc_ack_q;
    alloc_err    = enable & alloc_err_q;
    req_err      = enable & req_err_q;
    alloc_handle = alloc_handle_q;
    out_handle   = hdl_q;
    out_data     = out_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      n_alloc_q      <= '0;
      next_base_q    <= '0;
      hdl_q          <= '0;
      data_q         <= '0;
      inc_q          <= '0;
      out_data_q     <= '0;
      alloc_handle_q <= '0;
      alloc_ack_q    <= 1'b0;
      alloc_err_q    <= 1'b0;
      req_err_q      <= 1'b0;
`ifdef DELAY_INTERP_EN
      s0_q           <= '0;
`endif
      for (int i = 0; i < N_CH; i++) chan_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      n_alloc_q      <= n_alloc_d;
      next_base_q    <= next_base_d;
      hdl_q          <= hdl_d;
      data_q         <= data_d;
      inc_q          <= inc_d;
      out_data_q     <= out_data_d;
      alloc_handle_q <= alloc_handle_d;
      alloc_ack_q    <= alloc_ack_d;
      alloc_err_q    <= alloc_err_d;
      req_err_q      <= req_err_d;
`ifdef DELAY_INTERP_EN
      s0_q           <= s0_d;
`endif
      chan_q         <= chan_d;
    end
  end

  // Sample RAM: not reset. Registered read; the write in WR lands before
  // the RD0 read, so a zero delay returns the sample just written.
  assign ram_rdata_d = mem[raddr];
  always_ff @(posedge clk) begin
    if (enable) begin
      if (state_q == S_WR) mem[waddr] <= data_q;
      ram_rdata_q <= ram_rdata_d;
    end
  end
endmodule
